// File: rtl/dyn_phase_shift_ctrl.sv
// Dynamic phase-shift controller: single-step PSEN/PSINCDEC requests, wrapped 0..359 degree accumulator, fixed-latency PSDONE.
// Optional macro DPS_OVERRUN_EN adds a sticky ps_overrun flag for dropped requests.
module dyn_phase_shift_ctrl #(
   parameter int STEP_DEG   = 1,
   parameter int PSDONE_LAT = 12,
   parameter int INIT_SHIFT = 0
) (
   input  logic               clk,
   input  logic               RST_N,
   input  logic               PWRDWN,
   input  logic               LOCKED,
   input  logic               PSEN,
   input  logic               PSINCDEC,
   output logic               PSDONE,
   output logic               busy,
   output logic signed [31:0] shift
`ifdef DPS_OVERRUN_EN
   ,
   output logic               ps_overrun
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   logic [7:0]         count_r;
   logic signed [31:0] shift_r;
   logic               psdone_r;
   logic               busy_r;
   logic               locked_s;
   logic               accept_s;
   logic signed [31:0] next_shift_s;

   function automatic logic signed [31:0] wrap_step(input logic signed [31:0] cur, input logic inc);
      logic signed [31:0] nxt;
      if (inc) begin
         nxt = cur + 32'(STEP_DEG);
         if (nxt >= 32'sd360) nxt = nxt - 32'sd360;
      end else begin
         nxt = cur - 32'(STEP_DEG);
         if (nxt < 32'sd0) nxt = nxt + 32'sd360;
      end
      return nxt;
   endfunction

   // Request qualification and next accumulator value; an X on LOCKED is not a lock.
   always_comb begin
      locked_s     = (LOCKED === 1'b1);
      next_shift_s = wrap_step(shift_r, PSINCDEC);
      if (PSEN && locked_s && !PWRDWN && (state_r == IDLE)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Handshake FSM: accept, count down the latency, pulse PSDONE, return to idle.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         state_r  <= IDLE;
         count_r  <= 8'd0;
         shift_r  <= 32'(INIT_SHIFT);
         psdone_r <= 1'b0;
         busy_r   <= 1'b0;
      end else if (PWRDWN) begin
         state_r  <= IDLE;
         count_r  <= 8'd0;
         psdone_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               psdone_r <= 1'b0;
               if (accept_s) begin
                  shift_r <= next_shift_s;
                  busy_r  <= 1'b1;
                  count_r <= 8'(PSDONE_LAT - 1);
                  state_r <= BUSY;
               end
            end
            BUSY: begin
               if (count_r == 8'd0) begin
                  psdone_r <= 1'b1;
                  state_r  <= DONE;
               end else begin
                  count_r <= count_r - 8'd1;
               end
            end
            DONE: begin
               psdone_r <= 1'b0;
               busy_r   <= 1'b0;
               state_r  <= IDLE;
            end
            default: begin
               psdone_r <= 1'b0;
               busy_r   <= 1'b0;
               count_r  <= 8'd0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign PSDONE = psdone_r;
   assign busy   = busy_r;
   assign shift  = shift_r;

`ifdef DPS_OVERRUN_EN
   logic overrun_r;

   // Sticky flag for requests dropped while busy or unlocked; power-down drops are exempt.
   always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
         overrun_r <= 1'b0;
      end else if (PSEN && !PWRDWN && !accept_s) begin
         overrun_r <= 1'b1;
      end else begin
         overrun_r <= overrun_r;
      end
   end

   assign ps_overrun = overrun_r;
`endif

endmodule

// File: tb/tb_dyn_phase_shift_ctrl.sv
// Self-checking bench for dyn_phase_shift_ctrl: a STEP_DEG=1 and a STEP_DEG=45 instance share stimulus.
module tb_dyn_phase_shift_ctrl;
   localparam int LAT = 12;

   logic clk = 1'b0;
   logic RST_N = 1'b0;
   logic PWRDWN = 1'b0;
   logic LOCKED = 1'b1;
   logic PSEN = 1'b0;
   logic PSINCDEC = 1'b0;
   logic PSDONE, busy, PSDONE45, busy45;
   logic signed [31:0] shift, shift45;
`ifdef DPS_OVERRUN_EN
   logic ps_overrun, ps_overrun45;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int done45_cnt = 0;
   int exp_s;
   int exp_s45;

   typedef struct {
      logic locked;
      logic pwrdwn;
      logic inc;
      int   exp_shift;
      int   exp_shift45;
      int   exp_done;
   } vec_t;
   vec_t vecs[9];

   dyn_phase_shift_ctrl #(.STEP_DEG(1), .PSDONE_LAT(LAT), .INIT_SHIFT(0)) u_dut (
      .clk(clk), .RST_N(RST_N), .PWRDWN(PWRDWN), .LOCKED(LOCKED), .PSEN(PSEN),
      .PSINCDEC(PSINCDEC), .PSDONE(PSDONE), .busy(busy), .shift(shift)
`ifdef DPS_OVERRUN_EN
      , .ps_overrun(ps_overrun)
`endif
   );

   dyn_phase_shift_ctrl #(.STEP_DEG(45), .PSDONE_LAT(LAT), .INIT_SHIFT(340)) u_dut45 (
      .clk(clk), .RST_N(RST_N), .PWRDWN(PWRDWN), .LOCKED(LOCKED), .PSEN(PSEN),
      .PSINCDEC(PSINCDEC), .PSDONE(PSDONE45), .busy(busy45), .shift(shift45)
`ifdef DPS_OVERRUN_EN
      , .ps_overrun(ps_overrun45)
`endif
   );

   always #5 clk = ~clk;

   // PSDONE pulse counters, sampled away from the rising edge
   always @(negedge clk) begin
      if (PSDONE === 1'b1) done_cnt <= done_cnt + 1;
      if (PSDONE45 === 1'b1) done45_cnt <= done45_cnt + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_step(input int cur, input logic inc, input int step);
      int r;
      r = inc ? cur + step : cur - step;
      if (r >= 360) r = r - 360;
      if (r < 0) r = r + 360;
      return r;
   endfunction

   // One request issued at the current negedge; checks every cycle from E0 to E0+LAT+1.
   task automatic run_timed(input logic inc, input int lock_fall, input int pwr_at,
                            input int psen_a, input int psen_b, input string tag);
      int   done0;
      int   done45_0;
      logic aborted;
      done0    = done_cnt;
      done45_0 = done45_cnt;
      PSINCDEC = inc;
      PSEN     = 1'b1;
      @(negedge clk);
      PSEN    = 1'b0;
      exp_s   = model_step(exp_s, inc, 1);
      exp_s45 = model_step(exp_s45, inc, 45);
      for (int i = 0; i <= LAT + 1; i++) begin
         aborted = (pwr_at > 0) && (i >= pwr_at);
         check({tag, "_psdone"}, 32'(PSDONE), 32'(!aborted && (i == LAT)));
         check({tag, "_busy"}, 32'(busy), 32'(!aborted && (i <= LAT)));
         check({tag, "_shift"}, shift, exp_s);
         check({tag, "_shift45"}, shift45, exp_s45);
         PSEN   = (i + 1 == psen_a) || (i + 1 == psen_b);
         PWRDWN = (i + 1 == pwr_at);
         if (i + 1 == lock_fall) LOCKED = 1'b0;
         @(negedge clk);
      end
      PSEN   = 1'b0;
      PWRDWN = 1'b0;
      LOCKED = 1'b1;
      check({tag, "_pulses"}, 32'(done_cnt - done0), (pwr_at > 0) ? 32'd0 : 32'd1);
      check({tag, "_pulses45"}, 32'(done45_cnt - done45_0), (pwr_at > 0) ? 32'd0 : 32'd1);
   endtask

   initial begin
      int   d0;
      int   d45;
      logic inc;

      vecs[0] = '{1'b1, 1'b0, 1'b1, 1, 25, 1};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 340, 1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 359, 295, 1};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 0, 340, 1};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 0, 340, 0};
      vecs[5] = '{1'bx, 1'b0, 1'b1, 0, 340, 0};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 0, 340, 0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 359, 295, 1};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 358, 250, 1};

      repeat (3) @(negedge clk);
      check("rst_shift", shift, 32'd0);
      check("rst_shift45", shift45, 32'd340);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_psdone", 32'(PSDONE), 32'd0);
`ifdef DPS_OVERRUN_EN
      check("rst_overrun", 32'(ps_overrun), 32'd0);
`endif
      RST_N = 1'b1;
      @(negedge clk);
      exp_s   = 0;
      exp_s45 = 340;

      run_timed(1'b1, -1, -1, -1, -1, "basic_inc");

`ifdef DPS_OVERRUN_EN
      check("overrun_before", 32'(ps_overrun), 32'd0);
`endif
      run_timed(1'b1, -1, -1, 5, LAT + 1, "drop_busy_done");
`ifdef DPS_OVERRUN_EN
      check("overrun_after", 32'(ps_overrun), 32'd1);
      check("overrun45_after", 32'(ps_overrun45), 32'd1);
`endif

      // Asynchronous reset in the middle of a request
      d0       = done_cnt;
      PSINCDEC = 1'b1;
      PSEN     = 1'b1;
      @(negedge clk);
      PSEN = 1'b0;
      repeat (5) @(negedge clk);
      #2 RST_N = 1'b0;
      #1;
      check("midrst_shift", shift, 32'd0);
      check("midrst_shift45", shift45, 32'd340);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_psdone", 32'(PSDONE), 32'd0);
`ifdef DPS_OVERRUN_EN
      check("midrst_overrun", 32'(ps_overrun), 32'd0);
`endif
      @(negedge clk);
      RST_N = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      check("midrst_no_pulse", 32'(done_cnt - d0), 32'd0);
      check("midrst_busy_after", 32'(busy), 32'd0);

      for (int v = 0; v < 9; v++) begin
         d0       = done_cnt;
         LOCKED   = vecs[v].locked;
         PWRDWN   = vecs[v].pwrdwn;
         PSINCDEC = vecs[v].inc;
         PSEN     = 1'b1;
         @(negedge clk);
         PSEN   = 1'b0;
         LOCKED = 1'b1;
         PWRDWN = 1'b0;
         repeat (LAT + 2) @(negedge clk);
         check($sformatf("vec%0d_shift", v), shift, vecs[v].exp_shift);
         check($sformatf("vec%0d_shift45", v), shift45, vecs[v].exp_shift45);
         check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
         check($sformatf("vec%0d_pulses", v), 32'(done_cnt - d0), vecs[v].exp_done);
      end
      exp_s   = 358;
      exp_s45 = 250;

      run_timed(1'b0, -1, 6, -1, -1, "pwrdwn_abort");
      run_timed(1'b1, -1, -1, -1, -1, "after_pwrdwn");
      run_timed(1'b1, 3, -1, -1, -1, "lock_fall");

      d0  = done_cnt;
      d45 = done45_cnt;
      for (int r = 0; r < 100; r++) begin
         inc      = 1'($urandom_range(0, 1));
         PSINCDEC = inc;
         PSEN     = 1'b1;
         @(negedge clk);
         PSEN    = 1'b0;
         exp_s   = model_step(exp_s, inc, 1);
         exp_s45 = model_step(exp_s45, inc, 45);
         repeat (LAT + 1) @(negedge clk);
         check($sformatf("rand%0d_shift", r), shift, exp_s);
         check($sformatf("rand%0d_shift45", r), shift45, exp_s45);
      end
      @(negedge clk);
      check("rand_pulses", 32'(done_cnt - d0), 32'd100);
      check("rand_pulses45", 32'(done45_cnt - d45), 32'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
